// File: rtl/compdiv_iter.sv
// Sequential complex divider q = a / b: one cycle for a*conj(b) and |b|^2, then two
// parallel radix-2 restoring dividers sharing |b|^2, a sign/saturate step, and a held result.
module compdiv_iter #(
    parameter int N    = 8,
    parameter int FRAC = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   a_r,
    input  logic signed [N-1:0]   a_i,
    input  logic signed [N-1:0]   b_r,
    input  logic signed [N-1:0]   b_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*N-1:0] q_r,
    output logic signed [2*N-1:0] q_i,
    output logic                  div_zero,
    output logic                  ovf
);

    localparam int W  = 2*N + 1 + FRAC;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] LIM_POS = W'((1 << (2*N-1)) - 1);
    localparam logic [W-1:0] LIM_NEG = W'(1 << (2*N-1));

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, OUT} state_t;

    state_t                state_q, state_d;
    logic signed [N-1:0]   ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
    logic                  sgn_r_q, sgn_r_d, sgn_i_q, sgn_i_d, dz_q, dz_d;
    logic [2*N:0]          den_q, den_d;
    logic [2*N:0]          rem_r_q, rem_r_d, rem_i_q, rem_i_d;
    logic [W-1:0]          dvd_r_q, dvd_r_d, dvd_i_q, dvd_i_d;
    logic [W-1:0]          quo_r_q, quo_r_d, quo_i_q, quo_i_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [2*N-1:0] q_r_q, q_r_d, q_i_q, q_i_d;
    logic                  div_zero_q, div_zero_d, ovf_q, ovf_d;

    // Returns {ovf, q}: signed, truncated-toward-zero result clamped to the 2N-bit range.
    function automatic logic [2*N:0] sat_q(input logic neg, input logic [W-1:0] mag);
        logic [2*N:0] r;
        if (!neg) begin
            if (mag > LIM_POS) r = {1'b1, 1'b0, {(2*N-1){1'b1}}};
            else               r = {1'b0, mag[2*N-1:0]};
        end else begin
            if (mag > LIM_NEG) r = {1'b1, 1'b1, {(2*N-1){1'b0}}};
            else               r = {1'b0, -mag[2*N-1:0]};
        end
        return r;
    endfunction

    logic signed [2*N:0] ar_x, ai_x, br_x, bi_x, num_r, num_i;
    logic [2*N:0]        den_w, mag_r, mag_i;
    logic [2*N+1:0]      sh_r, sh_i;
    logic                ge_r, ge_i;
    logic [2*N:0]        sat_r, sat_i;

    assign ar_x  = (2*N+1)'(ar_q);
    assign ai_x  = (2*N+1)'(ai_q);
    assign br_x  = (2*N+1)'(br_q);
    assign bi_x  = (2*N+1)'(bi_q);
    assign num_r = ar_x * br_x + ai_x * bi_x;
    assign num_i = ai_x * br_x - ar_x * bi_x;
    assign den_w = $unsigned(br_x * br_x + bi_x * bi_x);
    assign mag_r = num_r[2*N] ? $unsigned(-num_r) : $unsigned(num_r);
    assign mag_i = num_i[2*N] ? $unsigned(-num_i) : $unsigned(num_i);

    // One restoring step: partial remainder gains the next dividend bit, then trial-subtract.
    assign sh_r  = {rem_r_q, dvd_r_q[W-1]};
    assign sh_i  = {rem_i_q, dvd_i_q[W-1]};
    assign ge_r  = (sh_r >= {1'b0, den_q});
    assign ge_i  = (sh_i >= {1'b0, den_q});
    assign sat_r = sat_q(sgn_r_q, quo_r_q);
    assign sat_i = sat_q(sgn_i_q, quo_i_q);

    always_comb begin
        state_d    = state_q;
        ar_d       = ar_q;
        ai_d       = ai_q;
        br_d       = br_q;
        bi_d       = bi_q;
        sgn_r_d    = sgn_r_q;
        sgn_i_d    = sgn_i_q;
        dz_d       = dz_q;
        den_d      = den_q;
        rem_r_d    = rem_r_q;
        rem_i_d    = rem_i_q;
        dvd_r_d    = dvd_r_q;
        dvd_i_d    = dvd_i_q;
        quo_r_d    = quo_r_q;
        quo_i_d    = quo_i_q;
        cnt_d      = cnt_q;
        q_r_d      = q_r_q;
        q_i_d      = q_i_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ar_d    = a_r;
                    ai_d    = a_i;
                    br_d    = b_r;
                    bi_d    = b_i;
                    state_d = MULT;
                end
            end
            MULT: begin
                sgn_r_d = num_r[2*N];
                sgn_i_d = num_i[2*N];
                den_d   = den_w;
                dz_d    = (den_w == '0);
                dvd_r_d = {mag_r, {FRAC{1'b0}}};
                dvd_i_d = {mag_i, {FRAC{1'b0}}};
                rem_r_d = '0;
                rem_i_d = '0;
                quo_r_d = '0;
                quo_i_d = '0;
                cnt_d   = CW'(W - 1);
                state_d = (den_w == '0) ? FIX : DIV;
            end
            DIV: begin
                rem_r_d = ge_r ? (sh_r[2*N:0] - den_q) : sh_r[2*N:0];
                rem_i_d = ge_i ? (sh_i[2*N:0] - den_q) : sh_i[2*N:0];
                quo_r_d = {quo_r_q[W-2:0], ge_r};
                quo_i_d = {quo_i_q[W-2:0], ge_i};
                dvd_r_d = {dvd_r_q[W-2:0], 1'b0};
                dvd_i_d = {dvd_i_q[W-2:0], 1'b0};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                div_zero_d = dz_q;
                if (dz_q) begin
                    q_r_d = '0;
                    q_i_d = '0;
                    ovf_d = 1'b0;
                end else begin
                    q_r_d = sat_r[2*N-1:0];
                    q_i_d = sat_i[2*N-1:0];
                    ovf_d = sat_r[2*N] | sat_i[2*N];
                end
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ar_q       <= '0;
            ai_q       <= '0;
            br_q       <= '0;
            bi_q       <= '0;
            sgn_r_q    <= 1'b0;
            sgn_i_q    <= 1'b0;
            dz_q       <= 1'b0;
            den_q      <= '0;
            rem_r_q    <= '0;
            rem_i_q    <= '0;
            dvd_r_q    <= '0;
            dvd_i_q    <= '0;
            quo_r_q    <= '0;
            quo_i_q    <= '0;
            cnt_q      <= '0;
            q_r_q      <= '0;
            q_i_q      <= '0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ar_q       <= ar_d;
            ai_q       <= ai_d;
            br_q       <= br_d;
            bi_q       <= bi_d;
            sgn_r_q    <= sgn_r_d;
            sgn_i_q    <= sgn_i_d;
            dz_q       <= dz_d;
            den_q      <= den_d;
            rem_r_q    <= rem_r_d;
            rem_i_q    <= rem_i_d;
            dvd_r_q    <= dvd_r_d;
            dvd_i_q    <= dvd_i_d;
            quo_r_q    <= quo_r_d;
            quo_i_q    <= quo_i_d;
            cnt_q      <= cnt_d;
            q_r_q      <= q_r_d;
            q_i_q      <= q_i_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign q_r       = q_r_q;
    assign q_i       = q_i_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_compdiv_iter.sv
// Bench for compdiv_iter: directed cases, reset/backpressure behaviour, and a randomized
// run against an integer-arithmetic reference of the complex quotient.
module tb_compdiv_iter;
    localparam int N    = 8;
    localparam int FRAC = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid, in_ready, out_valid, out_ready;
    logic signed [N-1:0]   a_r, a_i, b_r, b_i;
    logic signed [2*N-1:0] q_r, q_i;
    logic                  div_zero, ovf;

    compdiv_iter #(.N(N), .FRAC(FRAC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .q_r(q_r), .q_i(q_i), .div_zero(div_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] qr;
        logic [15:0] qi;
        logic        ovf;
        logic        dz;
    } res_t;

    int nasrt = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Quotient from plain integer arithmetic: division truncates toward zero, then clamp.
    function automatic res_t model(input int ar, input int ai, input int br, input int bi);
        longint nr, ni, den, tr, ti;
        res_t   r;
        r   = '0;
        nr  = longint'(ar) * br + longint'(ai) * bi;
        ni  = longint'(ai) * br - longint'(ar) * bi;
        den = longint'(br) * br + longint'(bi) * bi;
        if (den == 0) begin
            r.dz = 1'b1;
            return r;
        end
        tr = (nr * (longint'(1) << FRAC)) / den;
        ti = (ni * (longint'(1) << FRAC)) / den;
        if (tr > 32767) begin tr = 32767; r.ovf = 1'b1; end
        else if (tr < -32768) begin tr = -32768; r.ovf = 1'b1; end
        if (ti > 32767) begin ti = 32767; r.ovf = 1'b1; end
        else if (ti < -32768) begin ti = -32768; r.ovf = 1'b1; end
        r.qr = 16'(tr);
        r.qi = 16'(ti);
        return r;
    endfunction

    function automatic int rnd8();
        case ($urandom % 8)
            0:       return -128;
            1:       return 127;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    task automatic drive(input int ar, input int ai, input int br, input int bi);
        a_r = 8'(ar);
        a_i = 8'(ai);
        b_r = 8'(br);
        b_i = 8'(bi);
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, "_qr"}, {16'b0, $unsigned(q_r)}, {16'b0, e.qr});
        chk({tag, "_qi"}, {16'b0, $unsigned(q_i)}, {16'b0, e.qi});
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, e.ovf});
        chk({tag, "_dz"}, {31'b0, div_zero}, {31'b0, e.dz});
    endtask

    // Called #1 after an edge with the DUT idle; ends #1 after the transfer edge.
    task automatic run_op(input int ar, input int ai, input int br, input int bi,
                          input int exp_lat, input string tag);
        res_t e;
        int   lat;
        e = model(ar, ai, br, bi);
        drive(ar, ai, br, bi);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 100);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_inrdy_busy"}, {31'b0, in_ready}, 32'd0);
        chk_res(tag, e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_inrdy_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        res_t e;
        int   lat, seen, gap, ar, ai, br, bi, done;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_inrdy", {31'b0, in_ready}, 32'd1);
        chk("rst_ov", {31'b0, out_valid}, 32'd0);
        chk("rst_qr", {16'b0, $unsigned(q_r)}, 32'd0);
        chk("rst_qi", {16'b0, $unsigned(q_i)}, 32'd0);
        chk("rst_dz", {31'b0, div_zero}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);

        run_op(1, 1, 1, 1, 27, "one");
        chk("one_const_qr", {16'b0, $unsigned(q_r)}, 32'h0100);
        run_op(3, 4, 1, 2, 27, "trunc");
        chk("trunc_const_qr", {16'b0, $unsigned(q_r)}, 32'h0233);
        chk("trunc_const_qi", {16'b0, $unsigned(q_i)}, 32'hFF9A);
        run_op(-128, -128, 0, 1, 27, "sat");
        chk("sat_const_qr", {16'b0, $unsigned(q_r)}, 32'h8000);
        chk("sat_const_qi", {16'b0, $unsigned(q_i)}, 32'h7FFF);
        chk("sat_const_ovf", {31'b0, ovf}, 32'd1);
        run_op(5, -7, 0, 0, 2, "dz");
        chk("dz_const_dz", {31'b0, div_zero}, 32'd1);
        run_op(2, 0, 2, 0, 27, "after_dz");
        chk("after_dz_const_qr", {16'b0, $unsigned(q_r)}, 32'h0100);
        chk("after_dz_const_dz", {31'b0, div_zero}, 32'd0);

        // Reset while the dividers are running.
        drive(7, 3, 2, 1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_inrdy", {31'b0, in_ready}, 32'd1);
        chk("midrst_ov", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("midrst_no_out", seen, 0);

        // Backpressure with ignored input pulses.
        e = model(3, 4, 1, 2);
        drive(3, 4, 1, 2);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 100);
        chk("bp_lat", lat, 27);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            drive(rnd8(), rnd8(), rnd8(), rnd8());
            @(posedge clk); #1;
            chk("bp_ov_held", {31'b0, out_valid}, 32'd1);
            chk("bp_inrdy", {31'b0, in_ready}, 32'd0);
            chk("bp_qr_stable", {16'b0, $unsigned(q_r)}, {16'b0, e.qr});
            chk("bp_qi_stable", {16'b0, $unsigned(q_i)}, {16'b0, e.qi});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_xfer_ov", {31'b0, out_valid}, 32'd0);
        chk("bp_xfer_inrdy", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp_single_ov", {31'b0, out_valid}, 32'd0);

        // Randomized operations with random handshakes.
        for (int op = 0; op < 1000; op++) begin
            gap = $urandom % 3;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            ar = rnd8(); ai = rnd8();
            if ($urandom % 8 == 0) begin br = 0; bi = 0; end
            else begin br = rnd8(); bi = rnd8(); end
            e = model(ar, ai, br, bi);
            drive(ar, ai, br, bi);
            chk("rnd_inrdy", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b1;
            @(posedge clk); #1;
            done = 0;
            for (int c = 0; c < 200 && done == 0; c++) begin
                out_ready = 1'($urandom % 2);
                in_valid  = 1'($urandom % 2);
                drive(rnd8(), rnd8(), rnd8(), rnd8());
                if (out_valid && out_ready) begin
                    chk_res("rnd", e);
                    done = 1;
                end
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk("rnd_done", done, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end
endmodule
